ram_rd_ctrl: RTL and testbench

RAM_RD_CTRL -- requirements
Module: ram_rd_ctrl

---
 rtl/mem_controller_pkg.sv | 29 ++
 rtl/skid_fifo2.sv | 63 ++++++
 rtl/ram_rd_ctrl.sv | 97 +++++++++
 tb/tb_ram_rd_ctrl.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_controller_pkg.sv
// Shared constants and helpers for the RAM read-side controller.
package mem_controller_pkg;

  localparam int unsigned DefDataWidth   = 10;
  localparam int unsigned DefAddrWidth   = 12;
  localparam int unsigned OutBufDepth    = 2;
  localparam int unsigned OutBufCntWidth = $clog2(OutBufDepth + 1);

  typedef enum logic [1:0] {
    LvlHold,
    LvlInc,
    LvlDec
  } lvl_op_e;

  // A write into a full RAM is dropped unless a read frees a slot in the same cycle.
  function automatic lvl_op_e level_op(logic wr, logic rd, logic is_full);
    lvl_op_e op;
    op = LvlHold;
    if (wr && rd) begin
      op = LvlHold;
    end else if (wr && !is_full) begin
      op = LvlInc;
    end else if (rd) begin
      op = LvlDec;
    end
    return op;
  endfunction

endpackage

// File: rtl/skid_fifo2.sv
// Two-entry output FIFO (skid buffer) with push/pop handshake and occupancy count.
module skid_fifo2
  import mem_controller_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DefDataWidth
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      push,
  input  logic [DATA_WIDTH-1:0]     push_data,
  input  logic                      pop,
  output logic [DATA_WIDTH-1:0]     head_data,
  output logic                      not_empty,
  output logic [OutBufCntWidth-1:0] count
);

  localparam logic [OutBufCntWidth-1:0] Depth = OutBufCntWidth'(OutBufDepth);

  logic [DATA_WIDTH-1:0]     mem_q [OutBufDepth];
  logic                      wr_ptr_q;
  logic                      rd_ptr_q;
  logic [OutBufCntWidth-1:0] count_q;
  logic [OutBufCntWidth-1:0] count_d;
  logic                      do_push;
  logic                      do_pop;

  assign do_pop  = pop && (count_q != '0);
  assign do_push = push && ((count_q != Depth) || do_pop);

  always_comb begin
    count_d = count_q;
    unique case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < OutBufDepth; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= push_data;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (do_pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      count_q <= count_d;
    end
  end

  assign head_data = mem_q[rd_ptr_q];
  assign not_empty = (count_q != '0);
  assign count     = count_q;

endmodule

// File: rtl/ram_rd_ctrl.sv
// Read-side controller: tracks RAM occupancy and streams words into a 2-entry skid buffer.
// Optional sticky overflow flag ovf_err when RAM_RD_CTRL_OVF_CHK_EN is defined.
module ram_rd_ctrl
  import mem_controller_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DefDataWidth,
  parameter int unsigned ADDR_WIDTH = DefAddrWidth
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_req,
  output logic                  ram_rd_req,
  input  logic [DATA_WIDTH-1:0] ram_rd_data,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  input  logic                  out_ready,
`ifdef RAM_RD_CTRL_OVF_CHK_EN
  output logic                  ovf_err,
`endif
  output logic [ADDR_WIDTH:0]   level,
  output logic                  empty,
  output logic                  full
);

  localparam logic [ADDR_WIDTH:0] LevelMax = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam int unsigned         OccWidth = OutBufCntWidth + 1;
  localparam logic [OccWidth-1:0] OccMax   = OccWidth'(OutBufDepth);

  logic [ADDR_WIDTH:0]       level_q;
  logic [ADDR_WIDTH:0]       level_d;
  logic                      inflight_q;
  logic                      fifo_valid;
  logic [OutBufCntWidth-1:0] fifo_count;
  logic                      pop;
  logic [OccWidth-1:0]       occupancy;
  lvl_op_e                   op;

  assign pop       = fifo_valid && out_ready;
  assign full      = (level_q == LevelMax);
  assign empty     = (level_q == '0);
  assign level     = level_q;
  assign out_valid = fifo_valid;

  // pop can only be high with a non-empty buffer, so this never underflows.
  assign occupancy = {1'b0, fifo_count} + OccWidth'(inflight_q) - OccWidth'(pop);

  assign ram_rd_req = !empty && (occupancy < OccMax);

  assign op = level_op(wr_req, ram_rd_req, full);

  always_comb begin
    level_d = level_q;
    unique case (op)
      LvlInc:  level_d = level_q + 1'b1;
      LvlDec:  level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      level_q    <= '0;
      inflight_q <= 1'b0;
    end else begin
      level_q    <= level_d;
      inflight_q <= ram_rd_req;
    end
  end

`ifdef RAM_RD_CTRL_OVF_CHK_EN
  logic ovf_err_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ovf_err_q <= 1'b0;
    end else if (wr_req && full && !ram_rd_req) begin
      ovf_err_q <= 1'b1;
    end
  end

  assign ovf_err = ovf_err_q;
`endif

  skid_fifo2 #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_out_buf (
    .clk      (clk),
    .reset    (reset),
    .push     (inflight_q),
    .push_data(ram_rd_data),
    .pop      (pop),
    .head_data(out_data),
    .not_empty(fifo_valid),
    .count    (fifo_count)
  );

endmodule

// File: tb/tb_ram_rd_ctrl.sv
// Scoreboard bench for ram_rd_ctrl with a behavioural registered-read RAM model.
module tb_ram_rd_ctrl;

  localparam int DW  = 10;
  localparam int AW  = 3;
  localparam int Cap = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          wr_req;
  logic [DW-1:0] wr_data;
  logic          ram_rd_req;
  logic [DW-1:0] ram_rd_data;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic          out_ready;
  logic [AW:0]   level;
  logic          empty;
  logic          full;
`ifdef RAM_RD_CTRL_OVF_CHK_EN
  logic          ovf_err;
`endif

  int errors = 0;
  int checks = 0;
  int pop_cnt = 0;
  int rd_cnt = 0;
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] ram_q[$];
  logic          prev_stall;
  logic [DW-1:0] prev_data;

  always #5 clk = ~clk;

  ram_rd_ctrl #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .wr_req     (wr_req),
    .ram_rd_req (ram_rd_req),
    .ram_rd_data(ram_rd_data),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_ready  (out_ready),
`ifdef RAM_RD_CTRL_OVF_CHK_EN
    .ovf_err    (ovf_err),
`endif
    .level      (level),
    .empty      (empty),
    .full       (full)
  );

  task automatic check(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // RAM: registered read, writes dropped when full unless a read happens in the same cycle.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      ram_q.delete();
      ram_rd_data <= '0;
    end else begin
      if (ram_rd_req && ram_q.size() != 0) ram_rd_data <= ram_q.pop_front();
      if (wr_req && ram_q.size() < Cap) ram_q.push_back(wr_data);
    end
  end

  always @(negedge clk) begin
    if (ram_rd_req) rd_cnt <= rd_cnt + 1;
  end

  // Monitor: scoreboard compare on each transfer, plus hold check under backpressure.
  always @(negedge clk) begin
    if (reset) begin
      prev_stall <= 1'b0;
    end else begin
      if (prev_stall) begin
        check("hold_valid", out_valid, 1);
        check("hold_data", out_data, prev_data);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_extra: got %0h, required no word", out_data);
        end else begin
          check("sb_data", out_data, exp_q.pop_front());
        end
        pop_cnt <= pop_cnt + 1;
      end
      prev_stall <= out_valid && !out_ready;
      prev_data  <= out_data;
    end
  end

  task automatic drain(input string name);
    out_ready = 1'b1;
    for (int i = 0; i < 60 && exp_q.size() != 0; i++) tick();
    check(name, exp_q.size(), 0);
    tick();
    tick();
    check({name, "_empty"}, empty, 1);
    check({name, "_valid"}, out_valid, 0);
  endtask

  initial begin
    int base;
    int vcnt;
    int sent;
    reset     = 1'b1;
    wr_req    = 1'b0;
    wr_data   = '0;
    out_ready = 1'b0;
    tick();
    tick();
    check("rst_level", level, 0);
    check("rst_empty", empty, 1);
    check("rst_full", full, 0);
    check("rst_valid", out_valid, 0);
    check("rst_data", out_data, 0);
    check("rst_rdreq", ram_rd_req, 0);
`ifdef RAM_RD_CTRL_OVF_CHK_EN
    check("rst_ovf", ovf_err, 0);
`endif
    reset = 1'b0;
    tick();

    // Single word
    out_ready = 1'b1;
    wr_req = 1'b1; wr_data = 10'h155; exp_q.push_back(10'h155);
    check("no_rd_at_level0", ram_rd_req, 0);
    tick();
    wr_req = 1'b0;
    check("single_level1", level, 1);
    check("single_rdreq", ram_rd_req, 1);
    tick();
    check("single_level0", level, 0);
    check("single_not_yet", out_valid, 0);
    tick();
    check("single_valid", out_valid, 1);
    check("single_data", out_data, 10'h155);
    tick();
    check("single_done", out_valid, 0);

    // Backpressure
    out_ready = 1'b0;
    base = rd_cnt;
    for (int i = 1; i <= 5; i++) begin
      wr_req = 1'b1; wr_data = DW'(i); exp_q.push_back(DW'(i));
      tick();
    end
    wr_req = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    check("bp_reads", rd_cnt - base, 2);
    check("bp_level", level, 3);
    check("bp_valid", out_valid, 1);
    check("bp_head", out_data, 1);
    out_ready = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      check("bp_stream_valid", out_valid, 1);
      check("bp_stream_data", out_data, i);
      tick();
    end
    check("bp_after_valid", out_valid, 0);
    check("bp_after_level", level, 0);

    // Streaming: one word per cycle
    base = pop_cnt;
    vcnt = 0;
    for (int i = 0; i < 102; i++) begin
      wr_req = (i < 100);
      wr_data = DW'(10'h100 + i);
      if (i < 100) exp_q.push_back(DW'(10'h100 + i));
      tick();
      check("stream_level_le2", level <= 2, 1);
      if (i >= 2 && out_valid) vcnt++;
    end
    wr_req = 1'b0;
    check("stream_valid_cycles", vcnt, 100);
    tick();
    check("stream_pops", pop_cnt - base, 100);

    // Full
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      wr_req = 1'b1; wr_data = DW'(10'h200 + i); exp_q.push_back(DW'(10'h200 + i));
      tick();
    end
    wr_req = 1'b0;
    tick(); tick(); tick();
    check("full_level6", level, 6);
    check("full_not_yet", full, 0);
    for (int i = 8; i < 10; i++) begin
      wr_req = 1'b1; wr_data = DW'(10'h200 + i); exp_q.push_back(DW'(10'h200 + i));
      tick();
    end
    wr_req = 1'b0;
    check("full_level8", level, 8);
    check("full_flag", full, 1);
    wr_req = 1'b1; wr_data = 10'h3ff;
    check("full_no_rd", ram_rd_req, 0);
    tick();
    wr_req = 1'b0;
    check("full_saturate", level, 8);
    check("full_still", full, 1);
`ifdef RAM_RD_CTRL_OVF_CHK_EN
    check("full_ovf", ovf_err, 1);
`endif
    drain("full_drain");
    check("full_drain_level", level, 0);

    // Simultaneous write and read
    out_ready = 1'b0;
    wr_req = 1'b1; wr_data = 10'h0a1; exp_q.push_back(10'h0a1);
    tick();
    wr_data = 10'h0a2; exp_q.push_back(10'h0a2);
    check("simul_rdreq", ram_rd_req, 1);
    tick();
    wr_req = 1'b0;
    check("simul_level", level, 1);

    // Random backpressure
    sent = 0;
    for (int c = 0; c < 20000 && sent < 1000; c++) begin
      out_ready = 1'($urandom_range(0, 1));
      if (exp_q.size() < Cap && $urandom_range(0, 3) != 0) begin
        wr_req = 1'b1; wr_data = DW'($urandom_range(0, 1023));
        exp_q.push_back(wr_data);
        sent++;
      end else begin
        wr_req = 1'b0;
      end
      tick();
    end
    wr_req = 1'b0;
    check("rand_sent", sent, 1000);
    drain("rand_drain");

    // Reset with a read in flight
    out_ready = 1'b1;
    wr_req = 1'b1; wr_data = 10'h2aa;
    tick();
    wr_req = 1'b0;
    check("mrst_rdreq", ram_rd_req, 1);
    tick();
    base = pop_cnt;
    reset = 1'b1;
    #1;
    check("mrst_valid", out_valid, 0);
    check("mrst_level", level, 0);
    tick();
    check("mrst_valid_next", out_valid, 0);
    check("mrst_level_next", level, 0);
    reset = 1'b0;
    vcnt = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (out_valid) vcnt++;
    end
    check("mrst_no_stale", vcnt, 0);
    check("mrst_no_pop", pop_cnt - base, 0);
    check("mrst_empty", empty, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
